// File: rtl/inv_sub_shift_unit_if.sv
// Handshake bundle for the inverse ShiftRows/SubBytes unit.
// The master drives the input state and out_ready. The slave returns the result and status.
interface inv_sub_shift_unit_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/inv_sub_shift_unit.sv
// AES InvShiftRows + InvSubBytes on one 128-bit state.
// LANES bytes are processed per clock, so each state takes 16/LANES cycles.
module inv_sub_shift_unit #(
  parameter int LANES = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  inv_sub_shift_unit_if.slave  bus
);
  localparam int GROUPS = 16 / LANES;
  localparam int CW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;

  if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
    $error("inv_sub_shift_unit: LANES must be 1, 2, 4, 8 or 16");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic            in_ready_reg, in_ready_next;
  logic            out_valid_reg, out_valid_next;
  logic            busy_reg, busy_next;
  logic [7:0]      src_reg [16];
  logic [7:0]      src_next [16];
  logic [7:0]      res_reg [16];
  logic [7:0]      res_next [16];
  logic [7:0]      in_bytes [16];
  logic [7:0]      lane_sub [LANES];
  logic [3:0]      lane_dst [LANES];
  logic            last_group;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Inverse affine map, then the field inverse as b^254 (0 maps to 0).
  function automatic logic [7:0] inv_s(input logic [7:0] s);
    logic [7:0] b, t;
    b = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
    t = gf_mul(gf_mul(b, b), b);            // b^3
    t = gf_mul(gf_mul(t, t), b);            // b^7
    t = gf_mul(gf_mul(t, t), b);            // b^15
    t = gf_mul(gf_mul(t, t), b);            // b^31
    t = gf_mul(gf_mul(t, t), b);            // b^63
    t = gf_mul(gf_mul(t, t), b);            // b^127
    return gf_mul(t, t);                    // b^254
  endfunction

  for (genvar gi = 0; gi < 16; gi++) begin : g_bytes
    assign in_bytes[gi] = bus.in_data[127-8*gi -: 8];
    assign bus.out_data[127-8*gi -: 8] = res_reg[gi];
  end

  // Each lane owns one destination byte. Its source sits in the same row, shifted left by row columns.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [3:0] dst;
    logic [1:0] row, col;
    assign dst          = 4'(int'(cnt_reg) * LANES + gi);
    assign row          = dst[1:0];
    assign col          = dst[3:2];
    assign lane_dst[gi] = dst;
    assign lane_sub[gi] = inv_s(src_reg[{col - row, row}]);
  end

  assign last_group    = (int'(cnt_reg) == GROUPS - 1);
  assign bus.in_ready  = in_ready_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.busy      = busy_reg;

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    in_ready_next  = in_ready_reg;
    out_valid_next = out_valid_reg;
    busy_next      = busy_reg;
    src_next       = src_reg;
    res_next       = res_reg;
    case (state_reg)
      IDLE: begin
        if (bus.in_valid) begin
          src_next      = in_bytes;
          cnt_next      = '0;
          state_next    = BUSY;
          in_ready_next = 1'b0;
          busy_next     = 1'b1;
        end
      end
      BUSY: begin
        for (int i = 0; i < LANES; i++) res_next[lane_dst[i]] = lane_sub[i];
        cnt_next = cnt_reg + 1'b1;
        if (last_group) begin
          cnt_next       = '0;
          state_next     = DONE;
          out_valid_next = 1'b1;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_next     = IDLE;
          out_valid_next = 1'b0;
          in_ready_next  = 1'b1;
          busy_next      = 1'b0;
        end
      end
      default: begin
        state_next     = IDLE;
        out_valid_next = 1'b0;
        in_ready_next  = 1'b1;
        busy_next      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        src_reg[i] <= '0;
        res_reg[i] <= '0;
      end
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      in_ready_reg  <= in_ready_next;
      out_valid_reg <= out_valid_next;
      busy_reg      <= busy_next;
      src_reg       <= src_next;
      res_reg       <= res_next;
    end
  end
endmodule

// File: tb/tb_inv_sub_shift_unit.sv
// Self-checking bench for inv_sub_shift_unit.
// It uses a LANES=4 main instance plus LANES=1/2/8/16 instances for the latency sweep.
module tb_inv_sub_shift_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  inv_sub_shift_unit_if m_if ();
  inv_sub_shift_unit #(.LANES(4)) u_dut (.clk(clk), .rst_n(rst_n), .bus(m_if));

  logic         sw_in_valid = 1'b0;
  logic [127:0] sw_in_data  = '0;
  logic         sw_out_ready = 1'b0;
  logic         sw_out_valid [4];
  logic         sw_in_ready [4];
  logic         sw_busy [4];
  logic [127:0] sw_out_data [4];

  for (genvar gi = 0; gi < 4; gi++) begin : g_sw
    localparam int L = (gi == 0) ? 1 : (gi == 1) ? 2 : (gi == 2) ? 8 : 16;
    inv_sub_shift_unit_if s_if ();
    assign s_if.in_valid    = sw_in_valid;
    assign s_if.in_data     = sw_in_data;
    assign s_if.out_ready   = sw_out_ready;
    assign sw_out_valid[gi] = s_if.out_valid;
    assign sw_in_ready[gi]  = s_if.in_ready;
    assign sw_busy[gi]      = s_if.busy;
    assign sw_out_data[gi]  = s_if.out_data;
    inv_sub_shift_unit #(.LANES(L)) u_sw (.clk(clk), .rst_n(rst_n), .bus(s_if));
  end

  int errors = 0;
  int checks = 0;
  int txn_no = 0;
  logic [7:0] inv_tab [256];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    int acc = 0;
    int aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ aa;
      aa = aa << 1;
      if (aa > 255) aa = (aa ^ 'h11b);
    end
    return 8'(acc);
  endfunction

  // Forward S-box from its definition (brute-force inverse + affine), then turned into a reverse lookup.
  task automatic build_model();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] v, s;
      v = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) v = 8'(y);
      s = 8'h63;
      for (int k = 0; k < 5; k++) s = s ^ ((v << k) | (v >> (8 - k)));
      inv_tab[s] = 8'(x);
    end
  endtask

  function automatic logic [127:0] model(input logic [127:0] st);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++)
      for (int rw = 0; rw < 4; rw++) begin
        int src = rw + 4 * ((c - rw + 4) % 4);
        int dst = rw + 4 * c;
        r[127-8*dst -: 8] = inv_tab[st[127-8*src -: 8]];
      end
    return r;
  endfunction

  // One full transaction on the main instance: accept, latency, result, optional stall, handshake.
  task automatic do_txn(input logic [127:0] din, input logic [127:0] exp, input int stall, input bit poke);
    int wait_cnt = 0;
    int lat = 0;
    while (!m_if.in_ready && wait_cnt < 50) begin
      @(negedge clk);
      wait_cnt++;
    end
    chk("ready_before_accept", m_if.in_ready, 1'b1);
    m_if.in_valid = 1'b1;
    m_if.in_data  = din;
    @(negedge clk);
    m_if.in_valid = 1'b0;
    m_if.in_data  = 128'($urandom) << 64 | 128'($urandom);
    while (!m_if.out_valid && lat < 40) begin
      if (m_if.in_ready !== 1'b0 || m_if.busy !== 1'b1) begin
        chk("busy_flags", {m_if.in_ready, m_if.busy}, 2'b01);
      end
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, 4);
    chk("out_data", m_if.out_data, exp);
    for (int i = 0; i < stall; i++) begin
      if (poke) begin
        m_if.in_valid = ~m_if.in_valid;
        m_if.in_data  = {4{$urandom}};
      end
      @(negedge clk);
      chk("stall_data", m_if.out_data, exp);
      chk("stall_flags", {m_if.out_valid, m_if.in_ready, m_if.busy}, 3'b101);
    end
    m_if.in_valid  = 1'b0;
    m_if.out_ready = 1'b1;
    @(negedge clk);
    m_if.out_ready = 1'b0;
    chk("after_handshake", {m_if.out_valid, m_if.in_ready, m_if.busy}, 3'b010);
    $display("txn %0d in=%h out=%h lat=%0d stall=%0d", txn_no, din, m_if.out_data, lat, stall);
    txn_no++;
  endtask

  typedef struct {
    logic [127:0] din;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs [5];

  initial begin
    logic [127:0] st;
    int seen_lat [4];
    int exp_lat [4];
    vecs[0] = '{128'h637c777bf26b6fc53001672bfed7ab76, 128'h000d0a07_04010e0b_0805020f_0c090603};
    vecs[1] = '{{16{8'h63}}, 128'h0};
    vecs[2] = '{{16{8'h00}}, {16{8'h52}}};
    vecs[3] = '{{16{8'h16}}, {16{8'hff}}};
    vecs[4] = '{{16{8'hed}}, {16{8'h53}}};
    exp_lat = '{16, 8, 2, 1};

    m_if.in_valid  = 1'b0;
    m_if.in_data   = '0;
    m_if.out_ready = 1'b0;
    build_model();
    chk("model_63", inv_tab[8'h63], 8'h00);
    chk("model_7c", inv_tab[8'h7c], 8'h01);
    chk("model_16", inv_tab[8'h16], 8'hff);

    // Reset state while held, then after a mid-cycle release.
    repeat (3) @(negedge clk);
    chk("rst_flags", {m_if.in_ready, m_if.out_valid, m_if.busy}, 3'b100);
    chk("rst_data", m_if.out_data, 128'h0);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_flags", {m_if.in_ready, m_if.out_valid, m_if.busy}, 3'b100);
    chk("post_rst_data", m_if.out_data, 128'h0);

    for (int i = 0; i < 5; i++) do_txn(vecs[i].din, vecs[i].exp, i % 3, 1'b0);

    // Every byte value 00..ff appears once across these 16 states.
    for (int i = 0; i < 16; i++) begin
      for (int k = 0; k < 16; k++) st[127-8*k -: 8] = 8'(16 * i + ((k * 5 + i) % 16));
      do_txn(st, model(st), 0, 1'b0);
    end

    // Backpressure with input noise during the stall.
    do_txn(vecs[0].din, vecs[0].exp, 10, 1'b1);

    for (int i = 0; i < 20; i++) begin
      st = {$urandom, $urandom, $urandom, $urandom};
      do_txn(st, model(st), $urandom_range(0, 3), 1'(i % 2));
    end

    // Abort mid-BUSY with reset, then run a fresh transaction.
    m_if.in_valid = 1'b1;
    m_if.in_data  = vecs[2].din;
    @(negedge clk);
    m_if.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_flags", {m_if.in_ready, m_if.out_valid, m_if.busy}, 3'b100);
    @(negedge clk);
    rst_n = 1'b1;
    do_txn(vecs[0].din, vecs[0].exp, 1, 1'b0);

    // Latency sweep across the other lane counts.
    seen_lat = '{0, 0, 0, 0};
    sw_in_valid = 1'b1;
    sw_in_data  = vecs[0].din;
    @(negedge clk);
    sw_in_valid = 1'b0;
    for (int cyc = 1; cyc <= 24; cyc++) begin
      @(negedge clk);
      for (int j = 0; j < 4; j++) begin
        if (seen_lat[j] == 0 && sw_out_valid[j]) seen_lat[j] = cyc;
      end
    end
    for (int j = 0; j < 4; j++) begin
      chk("sweep_latency", seen_lat[j], exp_lat[j]);
      chk("sweep_data", sw_out_data[j], vecs[0].exp);
      chk("sweep_flags", {sw_in_ready[j], sw_busy[j]}, 2'b01);
      $display("sweep lanes_idx=%0d lat=%0d out=%h", j, seen_lat[j], sw_out_data[j]);
    end
    sw_out_ready = 1'b1;
    @(negedge clk);
    sw_out_ready = 1'b0;
    for (int j = 0; j < 4; j++) chk("sweep_release", {sw_out_valid[j], sw_in_ready[j]}, 2'b01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
